// File: rtl/reg_cpu_slave_if.sv
// reg_cpu bus bundle: initiator drives cs/addr/data/we/re, responder returns
// rd_data/wack/rdv.
interface reg_cpu_slave_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 32
);
   logic          reg_cpu_cs;
   logic [AW-1:0] reg_cpu_addr;
   logic [DW-1:0] reg_cpu_wr_data;
   logic          reg_cpu_we;
   logic          reg_cpu_re;
   logic [DW-1:0] reg_cpu_rd_data;
   logic          reg_cpu_wack;
   logic          reg_cpu_rdv;

   modport master (
      output reg_cpu_cs, reg_cpu_addr, reg_cpu_wr_data, reg_cpu_we, reg_cpu_re,
      input  reg_cpu_rd_data, reg_cpu_wack, reg_cpu_rdv
   );

   modport slave (
      input  reg_cpu_cs, reg_cpu_addr, reg_cpu_wr_data, reg_cpu_we, reg_cpu_re,
      output reg_cpu_rd_data, reg_cpu_wack, reg_cpu_rdv
   );
endinterface

// File: rtl/reg_cpu_slave.sv
// reg_cpu responder holding the image-pipe config/status register bank.
// Optional REG_CPU_SLV_ADDR_ERR_EN: flag unmapped accesses in IRQ_STAT[7] and ERR_ADDR.
module reg_cpu_slave #(
   parameter int unsigned DW     = 32,
   parameter int unsigned AW     = 32,
   parameter int unsigned RD_LAT = 2
) (
   input  logic                 reg_cpu_clk,
   input  logic                 rst_n,
   reg_cpu_slave_if.slave       bus,
   output logic                 cfg_enable,
   output logic                 cfg_start,
   output logic [15:0]          cfg_img_width,
   output logic [15:0]          cfg_img_height,
   input  logic                 stat_busy,
   input  logic [3:0]           irq_set,
   output logic                 irq
);

   typedef enum logic [2:0] {IDLE, WR_ACK, RD_WAIT, RD_VALID, GAP} state_t;

   localparam logic [3:0] CNT_INIT = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

   state_t        state;
   logic [3:0]    cnt;
   logic [DW-1:0] rd_snap;
   logic [DW-1:0] rd_data_q;
   logic          wack_q;
   logic          rdv_q;

   logic [31:0]   img_size;
   logic [7:0]    irq_stat;
   logic [7:0]    irq_stat_nxt;
   logic [7:0]    irq_en;
   logic [DW-1:0] scratch;
`ifdef REG_CPU_SLV_ADDR_ERR_EN
   logic [DW-1:0] err_addr;
`endif

   logic [5:0]    word;
   logic          wr_acc;
   logic          rd_acc;
   logic          hit;
   logic [DW-1:0] rd_mux;
   logic          unused_addr_bits;

   assign word   = bus.reg_cpu_addr[7:2];
   assign wr_acc = (state == IDLE) && bus.reg_cpu_cs && bus.reg_cpu_we;
   assign rd_acc = (state == IDLE) && bus.reg_cpu_cs && bus.reg_cpu_re && !bus.reg_cpu_we;
   assign unused_addr_bits = ^{bus.reg_cpu_addr[AW-1:8], bus.reg_cpu_addr[1:0]};

   assign bus.reg_cpu_rd_data = rd_data_q;
   assign bus.reg_cpu_wack    = wack_q;
   assign bus.reg_cpu_rdv     = rdv_q;
   assign cfg_img_width       = img_size[15:0];
   assign cfg_img_height      = img_size[31:16];

   always_comb begin
      rd_mux = '0;
      hit    = 1'b1;
      case (word)
         6'h00:   rd_mux = DW'({cfg_enable, 1'b0});
         6'h01:   rd_mux = DW'(img_size);
         6'h02:   rd_mux = DW'(stat_busy);
         6'h03:   rd_mux = DW'(irq_stat);
         6'h04:   rd_mux = DW'(irq_en);
         6'h05:   rd_mux = scratch;
`ifdef REG_CPU_SLV_ADDR_ERR_EN
         6'h06:   rd_mux = err_addr;
`endif
         default: hit = 1'b0;
      endcase
   end

   // W1C applied first so a same-cycle event strobe always survives
   always_comb begin
      irq_stat_nxt = irq_stat;
      if (wr_acc && word == 6'h03)
         irq_stat_nxt = irq_stat_nxt & ~bus.reg_cpu_wr_data[7:0];
      irq_stat_nxt[3:0] = irq_stat_nxt[3:0] | irq_set;
`ifdef REG_CPU_SLV_ADDR_ERR_EN
      if ((wr_acc || rd_acc) && !hit)
         irq_stat_nxt[7] = 1'b1;
`endif
   end

   always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_enable <= 1'b0;
         cfg_start  <= 1'b0;
         img_size   <= 32'h01E0_0280;
         irq_stat   <= '0;
         irq_en     <= '0;
         scratch    <= '0;
         irq        <= 1'b0;
`ifdef REG_CPU_SLV_ADDR_ERR_EN
         err_addr   <= '0;
`endif
      end else begin
         cfg_start <= wr_acc && (word == 6'h00) && bus.reg_cpu_wr_data[0];
         irq_stat  <= irq_stat_nxt;
         irq       <= |(irq_stat & irq_en);
         if (wr_acc) begin
            case (word)
               6'h00:   cfg_enable <= bus.reg_cpu_wr_data[1];
               6'h01:   img_size   <= bus.reg_cpu_wr_data[31:0];
               6'h04:   irq_en     <= bus.reg_cpu_wr_data[7:0];
               6'h05:   scratch    <= bus.reg_cpu_wr_data;
               default: ;
            endcase
         end
`ifdef REG_CPU_SLV_ADDR_ERR_EN
         if ((wr_acc || rd_acc) && !hit)
            err_addr <= DW'(bus.reg_cpu_addr);
`endif
      end
   end

   always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rd_snap   <= '0;
         rd_data_q <= '0;
         wack_q    <= 1'b0;
         rdv_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_acc) begin
                  state  <= WR_ACK;
                  wack_q <= 1'b1;
               end else if (rd_acc) begin
                  if (RD_LAT <= 1) begin
                     state     <= RD_VALID;
                     rdv_q     <= 1'b1;
                     rd_data_q <= rd_mux;
                  end else begin
                     state   <= RD_WAIT;
                     rd_snap <= rd_mux;
                     cnt     <= CNT_INIT;
                  end
               end
            end
            WR_ACK: begin
               wack_q <= 1'b0;
               state  <= GAP;
            end
            RD_WAIT: begin
               if (cnt == 4'd0) begin
                  state     <= RD_VALID;
                  rdv_q     <= 1'b1;
                  rd_data_q <= rd_snap;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RD_VALID: begin
               rdv_q     <= 1'b0;
               rd_data_q <= '0;
               state     <= GAP;
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_cpu_slave.sv
// Directed bench for reg_cpu_slave: vector table plus hand sequences for
// start pulse, IRQ W1C race, we+re collision, held cs and mid-read reset.
module tb_reg_cpu_slave;
   localparam int unsigned DW     = 32;
   localparam int unsigned AW     = 32;
   localparam int unsigned RD_LAT = 2;

   logic        clk;
   logic        rst_n;
   logic        cfg_enable;
   logic        cfg_start;
   logic [15:0] cfg_img_width;
   logic [15:0] cfg_img_height;
   logic        stat_busy;
   logic [3:0]  irq_set;
   logic        irq;

   int unsigned n_pass;
   int unsigned n_total;
   logic        wack_at_n;
   logic        start_at_n;
   logic        start_at_n1;

   reg_cpu_slave_if #(.DW(DW), .AW(AW)) bus ();

   reg_cpu_slave #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
      .reg_cpu_clk    (clk),
      .rst_n          (rst_n),
      .bus            (bus.slave),
      .cfg_enable     (cfg_enable),
      .cfg_start      (cfg_start),
      .cfg_img_width  (cfg_img_width),
      .cfg_img_height (cfg_img_height),
      .stat_busy      (stat_busy),
      .irq_set        (irq_set),
      .irq            (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] set_with);
      @(negedge clk);
      bus.reg_cpu_cs = 1'b1; bus.reg_cpu_we = 1'b1; bus.reg_cpu_re = 1'b0;
      bus.reg_cpu_addr = a; bus.reg_cpu_wr_data = d; irq_set = set_with;
      @(posedge clk); #1;
      wack_at_n  = bus.reg_cpu_wack;
      start_at_n = cfg_start;
      bus.reg_cpu_cs = 1'b0; bus.reg_cpu_we = 1'b0; irq_set = 4'h0;
      chk("wack_high", 32'(wack_at_n), 32'd1);
      @(posedge clk); #1;
      start_at_n1 = cfg_start;
      chk("wack_low", 32'(bus.reg_cpu_wack), 32'd0);
      @(posedge clk);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      bit          seen;
      int unsigned lat;
      @(negedge clk);
      bus.reg_cpu_cs = 1'b1; bus.reg_cpu_re = 1'b1; bus.reg_cpu_we = 1'b0;
      bus.reg_cpu_addr = a;
      @(posedge clk); #1;
      bus.reg_cpu_cs = 1'b0; bus.reg_cpu_re = 1'b0;
      seen = 1'b0; lat = 0; d = '0;
      for (int unsigned j = 0; j < 20; j++) begin
         if (j > 0) begin @(posedge clk); #1; end
         if (bus.reg_cpu_rdv) begin
            seen = 1'b1; lat = j; d = bus.reg_cpu_rd_data;
            break;
         end
      end
      if (!seen) begin
         chk("rdv_timeout", 32'd0, 32'd1);
      end else begin
         chk("rd_latency", 32'(lat), 32'(RD_LAT - 1));
         @(posedge clk); #1;
         chk("rdv_pulse_end", {30'd0, bus.reg_cpu_rdv, |bus.reg_cpu_rd_data}, 32'd0);
         @(posedge clk);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic        busy;
   } vec_t;

   vec_t        vecs [18];
   logic [31:0] rd;
   int unsigned nw;
   int unsigned nr;
   bit          rdv_seen;

   initial begin
      n_pass = 0; n_total = 0;
      rst_n = 1'b0; stat_busy = 1'b0; irq_set = 4'h0;
      bus.reg_cpu_cs = 1'b0; bus.reg_cpu_we = 1'b0; bus.reg_cpu_re = 1'b0;
      bus.reg_cpu_addr = '0; bus.reg_cpu_wr_data = '0;

      vecs[0]  = '{1'b0, 32'h04,  32'h01E0_0280, 1'b0};
      vecs[1]  = '{1'b0, 32'h00,  32'h0,         1'b0};
      vecs[2]  = '{1'b0, 32'h0C,  32'h0,         1'b0};
      vecs[3]  = '{1'b0, 32'h10,  32'h0,         1'b0};
      vecs[4]  = '{1'b0, 32'h14,  32'h0,         1'b0};
      vecs[5]  = '{1'b1, 32'h14,  32'hA5A5_5A5A, 1'b0};
      vecs[6]  = '{1'b0, 32'h14,  32'hA5A5_5A5A, 1'b0};
      vecs[7]  = '{1'b1, 32'h04,  32'h1234_5678, 1'b0};
      vecs[8]  = '{1'b0, 32'h04,  32'h1234_5678, 1'b0};
      vecs[9]  = '{1'b1, 32'h10,  32'hFFFF_FF3C, 1'b0};
      vecs[10] = '{1'b0, 32'h10,  32'h0000_003C, 1'b0};
      vecs[11] = '{1'b0, 32'h08,  32'h1,         1'b1};
      vecs[12] = '{1'b0, 32'h08,  32'h0,         1'b0};
      vecs[13] = '{1'b1, 32'h08,  32'hFFFF_FFFF, 1'b0};
      vecs[14] = '{1'b0, 32'h08,  32'h0,         1'b0};
      vecs[15] = '{1'b0, 32'h114, 32'hA5A5_5A5A, 1'b0};
      vecs[16] = '{1'b1, 32'h20,  32'hDEAD_BEEF, 1'b0};
      vecs[17] = '{1'b0, 32'h40,  32'h0,         1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("rst_bus", {29'd0, bus.reg_cpu_wack, bus.reg_cpu_rdv, |bus.reg_cpu_rd_data}, 32'd0);
      chk("rst_cfg", {29'd0, cfg_enable, cfg_start, irq}, 32'd0);
      chk("rst_img", {cfg_img_height, cfg_img_width}, 32'h01E0_0280);

      for (int i = 0; i < 18; i++) begin
         stat_busy = vecs[i].busy;
         if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, 4'h0);
         else begin
            do_read(vecs[i].addr, rd);
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].data);
         end
      end
      stat_busy = 1'b0;

`ifdef REG_CPU_SLV_ADDR_ERR_EN
      do_read(32'h0C, rd); chk("err_irq_stat", rd, 32'h80);
      do_read(32'h18, rd); chk("err_addr", rd, 32'h40);
      do_write(32'h0C, 32'h80, 4'h0);
`else
      do_read(32'h0C, rd); chk("no_err_irq_stat", rd, 32'h0);
      do_read(32'h18, rd); chk("no_err_addr", rd, 32'h0);
`endif

      // CTRL start pulse and enable
      do_write(32'h00, 32'h3, 4'h0);
      chk("start_pulse", {30'd0, start_at_n, start_at_n1}, 32'h2);
      chk("cfg_enable", 32'(cfg_enable), 32'd1);
      do_read(32'h00, rd); chk("ctrl_rd", rd, 32'h2);
      chk("img_wh", {cfg_img_height, cfg_img_width}, 32'h1234_5678);

      // IRQ set / W1C race
      do_write(32'h10, 32'h1, 4'h0);
      chk("irq_idle", 32'(irq), 32'd0);
      @(negedge clk) irq_set = 4'h1;
      @(negedge clk) irq_set = 4'h0;
      @(posedge clk); #1;
      chk("irq_raise", 32'(irq), 32'd1);
      do_write(32'h0C, 32'h1, 4'h1);
      do_read(32'h0C, rd); chk("w1c_set_wins", rd, 32'h1);
      chk("irq_held", 32'(irq), 32'd1);
      do_write(32'h0C, 32'h1, 4'h0);
      do_read(32'h0C, rd); chk("w1c_clear", rd, 32'h0);
      chk("irq_drop", 32'(irq), 32'd0);

      // we+re collision with cs held three cycles
      nw = 0; nr = 0;
      @(negedge clk);
      bus.reg_cpu_cs = 1'b1; bus.reg_cpu_we = 1'b1; bus.reg_cpu_re = 1'b1;
      bus.reg_cpu_addr = 32'h14; bus.reg_cpu_wr_data = 32'h1111_2222;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
         if (bus.reg_cpu_wack) nw++;
         if (bus.reg_cpu_rdv) nr++;
         if (k == 2) begin
            bus.reg_cpu_cs = 1'b0; bus.reg_cpu_we = 1'b0; bus.reg_cpu_re = 1'b0;
         end
      end
      chk("collide_wack_cnt", 32'(nw), 32'd1);
      chk("collide_rdv_cnt", 32'(nr), 32'd0);
      do_read(32'h14, rd); chk("collide_scratch", rd, 32'h1111_2222);

      // reset asserted while a read is in RD_WAIT
      @(negedge clk) irq_set = 4'h1;
      @(negedge clk) irq_set = 4'h0;
      @(posedge clk); #1;
      chk("irq_pre_rst", 32'(irq), 32'd1);
      @(negedge clk);
      bus.reg_cpu_cs = 1'b1; bus.reg_cpu_re = 1'b1; bus.reg_cpu_addr = 32'h14;
      @(posedge clk); #1;
      bus.reg_cpu_cs = 1'b0; bus.reg_cpu_re = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_bus", {29'd0, bus.reg_cpu_wack, bus.reg_cpu_rdv, |bus.reg_cpu_rd_data}, 32'd0);
      chk("midrst_cfg", {29'd0, cfg_enable, cfg_start, irq}, 32'd0);
      rdv_seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (bus.reg_cpu_rdv) rdv_seen = 1'b1;
      end
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (bus.reg_cpu_rdv) rdv_seen = 1'b1;
      end
      chk("midrst_no_rdv", 32'(rdv_seen), 32'd0);
      do_read(32'h14, rd); chk("post_rst_scratch", rd, 32'h0);
      do_read(32'h04, rd); chk("post_rst_img", rd, 32'h01E0_0280);
      do_read(32'h10, rd); chk("post_rst_irq_en", rd, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
